// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits MSB first, 1 stop bit, valid/ready byte output
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int MID = (CLKS_PER_BIT - 1) / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] MID_C = CW'(MID);
    localparam logic [CW-1:0] CPB_C = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // With MID==0 the detection cycle is already the start-bit midpoint.
    localparam state_t AFTER_DETECT = (MID == 0) ? DATA : START;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   rx_s;

    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            assign sync_d = rx;
        end else begin : g_syncn
            assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        end
    endgenerate

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (valid_q && rx_ready) valid_d = 1'b0;
        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end

        // cnt holds the offset since the previous sample point.
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = ONE_C;
                    bit_d   = 3'd0;
                    state_d = AFTER_DETECT;
                end
            end
            START: begin
                if (cnt_q == MID_C) begin
                    cnt_d   = ONE_C;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            DATA: begin
                if (cnt_q == CPB_C) begin
                    shift_d = {shift_q[6:0], rx_s};
                    cnt_d   = ONE_C;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            STOP: begin
                if (cnt_q == CPB_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || rx_ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver matching the team's uart_tx framing:
  - start bit 0;
  - 8 data bits, MSB first;
  - one stop bit 1;
  - idle line high.
- Synchronises the async rx pin and samples each bit mid-period.
- Presents each received byte on a valid/ready output register.
- Sits at the chip serial input, feeding the sensor command/readout logic.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); the default of 1 matches uart_tx timing.
- SYNC_STAGES, 2, flops in the rx input synchroniser (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high.
- rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
- err_clr  input  1  one-cycle pulse that clears the sticky frame_err and overrun flags.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- busy  output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; the stop bit was sampled as 0.
- overrun  output  1  sticky; a completed byte was dropped because rx_valid was still pending.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE;
  - synchroniser flops=1;
  - shift register and bit/cycle counters=0;
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - Asserting reset mid-frame abandons the frame; no byte is delivered.
- rx_s is rx delayed by SYNC_STAGES flops. All decisions use rx_s only.
- MID = (CLKS_PER_BIT-1)/2 (integer division). Offsets below are in cycles, with the detection cycle as offset 0.
- IDLE:
  - if rx_s==0 this is the detection cycle;
  - if MID==0, go to DATA (start bit confirmed on the same cycle);
  - otherwise go to START.
- START:
  - at offset MID, if rx_s==0 go to DATA;
  - if rx_s==1, treat it as a glitch: go to IDLE with no flags set.
- DATA:
  - data bit k (k=0..7) is sampled at offset MID+(k+1)*CLKS_PER_BIT;
  - shift <= {shift[6:0], rx_s}, so the first sampled bit ends up as rx_data[7];
  - after the 8th sample, go to STOP.
- STOP:
  - sample at offset MID+9*CLKS_PER_BIT, then go to IDLE on the next cycle;
  - IDLE is able to detect a new start bit on the cycle right after the stop sample, so back-to-back frames (a 10-bit period) are supported.
- Delivery (evaluated on the stop-sample cycle, taking effect the next cycle):
  - stop==1 and (rx_valid==0, or rx_ready==1 this cycle): rx_data<=shift, rx_valid<=1.
  - stop==1, rx_valid==1 and rx_ready==0: the byte is dropped, overrun<=1, and rx_data is unchanged.
  - stop==0: frame_err<=1, the byte is discarded, and rx_valid/rx_data are unchanged (apart from a normal handshake).
- Handshake:
  - rx_valid&&rx_ready clears rx_valid next cycle, unless a delivery occurs on the same cycle, in which case rx_valid stays 1 holding the new byte;
  - rx_data is stable while rx_valid=1 and rx_ready=0.
- err_clr:
  - clears both sticky flags next cycle;
  - if err_clr coincides with a new error event, the error wins (flag stays 1).
- busy: 1 in START/DATA/STOP, 0 in IDLE; registered together with the state.
- Latency: a start bit first appearing on rx at cycle c yields rx_valid=1 at cycle c+SYNC_STAGES+MID+9*CLKS_PER_BIT+1. With the defaults this is c+12.

Test Plan:
- Defaults; uart_tx sends 0xA5 with rx_ready=1 → rx_valid pulses 1 cycle at c+12, rx_data=0xA5, frame_err=0, overrun=0.
- Defaults; uart_tx sends 0x3C then 0xC3 back-to-back with rx_ready held 0 → first byte 0x3C held; second byte dropped; overrun=1; rx_data stays 0x3C. Then pulse rx_ready → rx_valid=0. Then pulse err_clr → overrun=0.
- CLKS_PER_BIT=4; drive frame 0x81 with stop bit forced 0 → frame_err=1, rx_valid stays 0. Next valid frame 0x7E → rx_data=0x7E, frame_err still 1 until err_clr.
- CLKS_PER_BIT=8; 2-cycle low glitch on idle rx → START aborts at offset MID=3, busy returns to 0, no rx_valid, no flags.
- Defaults; assert rst_n=0 after bit 4 of 0xFF → all outputs 0 and busy=0 immediately. Following frame 0x55 after reset release → rx_data=0x55.
- Defaults; rx_ready asserted on the exact cycle a second byte is delivered → rx_valid stays 1, rx_data updates to the new byte, overrun=0.
